// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: RV32I encoder types, opcode/funct7 constants and the encode function; RV_ENC_RANGE_CHECK_EN adds immediate/alt legality checks
package rv_enc_pkg;
  typedef enum logic [3:0] {
    FMT_R, FMT_OPIMM, FMT_LOAD, FMT_STORE, FMT_BRANCH,
    FMT_LUI, FMT_AUIPC, FMT_JALR, FMT_JAL, FMT_SYSTEM
  } fmt_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
  typedef struct packed {
    logic [31:0] word;
    logic        legal;
  } enc_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
`ifdef RV_ENC_RANGE_CHECK_EN
  function automatic logic range_ok(input logic [3:0] fmt, input logic [2:0] f3, input logic alt,
                                    input logic [31:0] imm);
    logic signed [31:0] s;
    logic i_ok;
    s = imm;
    i_ok = s >= -2048 && s <= 2047;
    case (fmt)
      FMT_R:                         return !alt || f3 == 3'b000 || f3 == 3'b101;
      FMT_OPIMM:                     return (f3 == 3'b001 || f3 == 3'b101) ?
                                       (imm < 32'd32 && (!alt || f3 == 3'b101)) : (i_ok && !alt);
      FMT_LOAD, FMT_STORE, FMT_JALR: return i_ok;
      FMT_BRANCH:                    return s >= -4096 && s <= 4095 && !imm[0];
      FMT_LUI, FMT_AUIPC:            return imm[11:0] == 12'd0;
      FMT_JAL:                       return s >= -1048576 && s <= 1048575 && !imm[0];
      FMT_SYSTEM:                    return imm < 32'd2;
      default:                       return 1'b0;
    endcase
  endfunction
`endif
  function automatic enc_t rv_encode(input logic [3:0] fmt, input logic [2:0] f3, input logic alt,
                                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm);
    logic [6:0] f7;
    enc_t r;
    f7 = alt ? F7_ALT : F7_BASE;
    case (fmt)
      FMT_R:      r.word = {f7, rs2, rs1, f3, rd, OP_R};
      FMT_OPIMM:  r.word = (f3 == 3'b001 || f3 == 3'b101) ? {f7, imm[4:0], rs1, f3, rd, OP_IMM}
                                                          : {imm[11:0], rs1, f3, rd, OP_IMM};
      FMT_LOAD:   r.word = {imm[11:0], rs1, f3, rd, OP_LOAD};
      FMT_STORE:  r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      FMT_BRANCH: r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      FMT_LUI:    r.word = {imm[31:12], rd, OP_LUI};
      FMT_AUIPC:  r.word = {imm[31:12], rd, OP_AUIPC};
      FMT_JALR:   r.word = {imm[11:0], rs1, f3, rd, OP_JALR};
      FMT_JAL:    r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      FMT_SYSTEM: r.word = {11'd0, imm[0], 13'd0, OP_SYSTEM};
      default:    r.word = '0;
    endcase
`ifdef RV_ENC_RANGE_CHECK_EN
    r.legal = fmt < 4'd10 && range_ok(fmt, f3, alt, imm);
`else
    r.legal = fmt < 4'd10;
`endif
    return r;
  endfunction
endpackage

// File: rtl/rv_instr_encoder_if.sv
// rv_instr_encoder_if: command-in and word-out handshakes of the instruction encoder
interface rv_instr_encoder_if #(parameter int ADDR_W = 12);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_fmt;
  logic [2:0]        in_funct3;
  logic              in_alt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  modport slave(input in_valid, in_fmt, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
                output in_ready, out_valid, out_word, out_addr);
  modport master(output in_valid, in_fmt, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
                 input in_ready, out_valid, out_word, out_addr);
endinterface

// File: rtl/rv_enc_fifo.sv
// rv_enc_fifo: synchronous FIFO with full/empty flags; a push while full is dropped even alongside a pop
module rv_enc_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= (push && !full) ? wp + 1'b1 : wp;
      rp <= (pop && !empty) ? rp + 1'b1 : rp;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs RV32I field commands into words and streams them with byte addresses toward IMEM
module rv_instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  rv_instr_encoder_if.slave   bus,
  output logic                done,
  output logic                err,
  output logic [7:0]          err_cnt
);
  state_e state, state_n;
  enc_t enc;
  logic full, empty, in_fire, out_fire, go, bad;
  logic [32:0] rd_data;
  logic [ADDR_W-1:0] addr;
  assign enc = rv_encode(bus.in_fmt, bus.in_funct3, bus.in_alt, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
  assign go = state == ST_IDLE && start;
  assign bus.in_ready = state == ST_RUN && !full;
  assign in_fire = bus.in_valid && bus.in_ready;
  assign bad = in_fire && !enc.legal;
  assign bus.out_valid = !empty;
  assign out_fire = bus.out_valid && bus.out_ready;
  // the FIFO array is never reset, so the word is masked while nothing is queued
  assign bus.out_word = empty ? '0 : rd_data[31:0];
  assign bus.out_addr = addr;
  assign done = state == ST_DONE;
  rv_enc_fifo #(.DEPTH(DEPTH), .W(33)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(in_fire && enc.legal), .wdata({bus.in_last, enc.word}),
    .pop(out_fire), .rdata(rd_data), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = go ? ST_RUN :
              (state == ST_RUN && in_fire && bus.in_last) ? ST_DRAIN :
              (state == ST_DRAIN && empty) ? ST_DONE :
              (state == ST_DONE) ? ST_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= BASE_ADDR;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      addr <= go ? BASE_ADDR : out_fire ? addr + ADDR_W'(4) : addr;
      err <= go ? 1'b0 : bad ? 1'b1 : err;
      err_cnt <= go ? '0 : (bad && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end
endmodule

// File: doc/rv_instr_encoder.md
# rv_instr_encoder

Sequential RV32I instruction encoder and program loader: the encode-side counterpart of the core's control-unit decoder. It accepts field-level instruction commands (format, funct3, alt bit, rd, rs1, rs2, immediate) over a valid/ready handshake and packs each into a 32-bit instruction word. Words are buffered in a FIFO and streamed out with an auto-incrementing byte address toward instruction memory. It sits between the bench/boot host and the IMEM write port.

## Interface
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- ADDR_W, 12, output byte-address width
- BASE_ADDR, 0, first output address (word aligned)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; IDLE→RUN, reloads address to BASE_ADDR
- in_valid / in_ready  in / out  1 / 1  command handshake
- in_fmt  in  4  0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JALR, 8 JAL, 9 SYSTEM; 10–15 illegal
- in_funct3  in  3  funct3 field
- in_alt  in  1  selects funct7=0100000 (sub/sra/srai)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed immediate (byte offset for B/JAL; full value for U)
- in_last  in  1  marks final command of program
- out_valid / out_ready  out / in  1 / 1  word handshake
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_word
- done  out  1  one-cycle pulse after final word accepted
- err  out  1  sticky; set by any rejected command, cleared by start
- err_cnt  out  8  rejected-command count, saturating at 255, cleared by start

## Operation
- States: IDLE (in_ready=0), RUN, DRAIN (in_ready=0), DONE.
- IDLE→RUN on start. RUN→DRAIN when a command with in_last=1 is accepted. DRAIN→DONE when FIFO empty and no out handshake pending. DONE→IDLE unconditionally next cycle; done=1 only in DONE.
- in_ready = (state==RUN) && !full. Accepted legal commands are pushed; illegal ones are handshaken, dropped, and set err/err_cnt.
- Opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1100111, 1101111, 1110011.
- R: funct7 = in_alt?0100000:0; alt legal only with funct3 000/101.
- OP-IMM funct3 001/101: shamt=in_imm[4:0], funct7 from in_alt (alt legal only with 101); other funct3: imm[11:0].
- S/B/J immediates scattered per RV32I; U uses in_imm[31:12]. SYSTEM: imm 0 ecall, 1 ebreak, all other fields zero.
- out_addr starts at BASE_ADDR, +4 per out handshake, wraps modulo 2^ADDR_W.
- out_valid = !empty; out_word/out_addr hold stable while out_valid && !out_ready.
- Simultaneous push and pop: allowed when not full; occupancy unchanged. No push when full, even with a concurrent pop.
- start while not IDLE: ignored.

## Timing
- Reset: state IDLE, FIFO empty, in_ready=0, out_valid=0, out_word=0, out_addr=BASE_ADDR, done=0, err=0, err_cnt=0.
- Latency: command accepted in cycle N → out_valid in N+1.
- Throughput: one command and one word per cycle.
- Reset mid-operation flushes FIFO and returns to IDLE immediately, regardless of clock.

## Configuration
- RV_ENC_RANGE_CHECK_EN defined: commands are illegal when in_fmt ≥10, I/LOAD/JALR/S imm is outside −2048..2047, shamt >31, B imm is outside ±4096 or odd, JAL imm is outside ±1 MiB or odd, U imm[11:0]≠0, SYSTEM imm is not 0/1, or alt misuse is present.
- Not defined: only in_fmt ≥10 is illegal; immediates are silently truncated and alt is applied as given.

## Structure
- Package rv_enc_pkg: format enum, the 7-bit opcode constants, funct7 constants, and an encode function returning a word plus a legal flag.
- One sub-module, rv_enc_fifo: synchronous FIFO with DEPTH entries, push/pop, full/empty flags and a 33-bit payload (word plus a last bit).

## Test plan
- start, then addi x1,x0,5 (fmt1,f3 0,rd1,imm5,last) with out_ready=1 → 0x00500093 at addr 0x000, then done pulse, return to IDLE.
- sub x3,x1,x2 followed by sw x2,8(x1) → 0x402081B3 @0x000, 0x0020A423 @0x004.
- beq x1,x2,−4 then jal x1,2048 → 0xFE208EE3, 0x001000EF.
- out_ready=0, push DEPTH commands → in_ready=0 once full; release → words emerge in order with stable data while stalled.
- With RV_ENC_RANGE_CHECK_EN, addi imm=3000 → dropped, err=1, err_cnt=1, no word out; same stimulus without the macro → 0xBB800013.
- Assert rst_n low mid-DRAIN with 3 words queued → out_valid=0 and state IDLE at once; start then restarts at BASE_ADDR.
